// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32/RV64 instruction decode stage with ID/EX register
//
// Purpose: decodes the fetched instruction combinationally, reads the register
// file in the same cycle, detects load-use hazards against the load held in EX,
// and registers the decoded payload into the ID/EX register (1-cycle latency).
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   if_valid_i / if_ready_o     fetch slot handshake
//   if_pc_i, if_instr_i         fetched PC and instruction
//   rs1/rs2_idx_o, _en_o        register file read index and enable
//   rs1/rs2_rdata_i             register file read data (same cycle)
//   ex_ld_valid_i, ex_ld_rd_i   load currently in EX and its destination
//   flush_i                     kill stage contents
//   ex_valid_o / ex_ready_i     ID/EX register handshake
//   ex_*_o                      registered decoded payload
//   stall_cnt_o                 saturating count of load-use stall cycles

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif

module decode_stage #(
  parameter int XLEN  = 32,
  parameter int MEXT  = 0,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_valid_i,
  output logic                      if_ready_o,
  input  logic [`PC_WIDTH-1:0]      if_pc_i,
  input  logic [`INSTR_WIDTH-1:0]   if_instr_i,
  output logic [`REG_IDX_WIDTH-1:0] rs1_idx_o,
  output logic [`REG_IDX_WIDTH-1:0] rs2_idx_o,
  output logic                      rs1_en_o,
  output logic                      rs2_en_o,
  input  logic [XLEN-1:0]           rs1_rdata_i,
  input  logic [XLEN-1:0]           rs2_rdata_i,
  input  logic                      ex_ld_valid_i,
  input  logic [`REG_IDX_WIDTH-1:0] ex_ld_rd_i,
  input  logic                      flush_i,
  output logic                      ex_valid_o,
  input  logic                      ex_ready_i,
  output logic [`PC_WIDTH-1:0]      ex_pc_o,
  output logic [`INSTR_WIDTH-1:0]   ex_instr_o,
  output logic [`REG_IDX_WIDTH-1:0] ex_rd_idx_o,
  output logic                      ex_rd_en_o,
  output logic [XLEN-1:0]           ex_imm_o,
  output logic [XLEN-1:0]           ex_alu_op1_o,
  output logic [XLEN-1:0]           ex_alu_op2_o,
  output logic [4:0]                ex_alu_fun_o,
  output logic                      ex_illegal_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BXX   = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_ALI   = 7'b0010011;
  localparam logic [6:0] OP_AL    = 7'b0110011;
  localparam logic [6:0] OP_CSR   = 7'b1110011;

  localparam logic [4:0] FUN_ADD   = 5'd0;
  localparam logic [4:0] FUN_SUB   = 5'd1;
  localparam logic [4:0] FUN_SUB_U = 5'd2;
  localparam logic [4:0] FUN_SLL   = 5'd3;
  localparam logic [4:0] FUN_SRL   = 5'd4;
  localparam logic [4:0] FUN_SRA   = 5'd5;
  localparam logic [4:0] FUN_XOR   = 5'd6;
  localparam logic [4:0] FUN_OR    = 5'd7;
  localparam logic [4:0] FUN_AND   = 5'd8;
  localparam logic [4:0] FUN_MUL   = 5'd10;

  localparam bit X64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] fun3;
  logic [6:0] fun7;
  logic [4:0] rd_idx;

  assign opcode = if_instr_i[6:0];
  assign fun3   = if_instr_i[14:12];
  assign fun7   = if_instr_i[31:25];
  assign rd_idx = if_instr_i[11:7];

  // Immediates, sign-extended to XLEN through a signed size cast
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  assign imm_i = XLEN'($signed(if_instr_i[31:20]));
  assign imm_s = XLEN'($signed({if_instr_i[31:25], if_instr_i[11:7]}));
  assign imm_b = XLEN'($signed({if_instr_i[31], if_instr_i[7], if_instr_i[30:25],
                                if_instr_i[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({if_instr_i[31], if_instr_i[19:12], if_instr_i[20],
                                if_instr_i[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({if_instr_i[31:12], 12'b0}));

  // Register operands; x0 always reads as zero whatever the regfile returns
  logic [XLEN-1:0] rs1_val, rs2_val, pc_ext, zimm_ext;
  assign rs1_val = (if_instr_i[19:15] == 5'd0) ? '0 : rs1_rdata_i;
  assign rs2_val = (if_instr_i[24:20] == 5'd0) ? '0 : rs2_rdata_i;

  always_comb begin
    pc_ext = '0;
    pc_ext[`PC_WIDTH-1:0] = if_pc_i;
    zimm_ext = '0;
    zimm_ext[4:0] = if_instr_i[19:15];
  end

  // Shift-immediate legality: RV64 uses a 6-bit shamt, so one fewer upper bit
  // must be zero; for srai bit 30 is the arithmetic select and is excluded.
  logic shl_bad, shr_bad;
  assign shl_bad = X64 ? (if_instr_i[31:26] != 6'd0) : (if_instr_i[31:25] != 7'd0);
  assign shr_bad = X64 ? ({if_instr_i[31], if_instr_i[29:26]} != 5'd0)
                       : ({if_instr_i[31], if_instr_i[29:25]} != 6'd0);

  logic            dec_ill, dec_rs1, dec_rs2, dec_rd;
  logic [4:0]      dec_fun;
  logic [XLEN-1:0] dec_imm, dec_op1, dec_op2;

  always_comb begin
    dec_ill = 1'b0;
    dec_rs1 = 1'b0;
    dec_rs2 = 1'b0;
    dec_rd  = 1'b0;
    dec_fun = FUN_ADD;
    dec_imm = '0;
    dec_op1 = '0;
    dec_op2 = '0;
    case (opcode)
      OP_LUI: begin
        dec_rd  = 1'b1;
        dec_imm = imm_u;
        dec_op2 = imm_u;
      end
      OP_AUIPC: begin
        dec_rd  = 1'b1;
        dec_imm = imm_u;
        dec_op1 = pc_ext;
        dec_op2 = imm_u;
      end
      OP_JAL: begin
        dec_rd  = 1'b1;
        dec_imm = imm_j;
        dec_op1 = pc_ext;
        dec_op2 = imm_j;
      end
      OP_JALR: begin
        dec_rs1 = 1'b1;
        dec_rd  = 1'b1;
        dec_imm = imm_i;
        dec_op1 = rs1_val;
        dec_op2 = imm_i;
      end
      OP_BXX: begin
        dec_rs1 = 1'b1;
        dec_rs2 = 1'b1;
        dec_imm = imm_b;
        dec_op1 = rs1_val;
        dec_op2 = rs2_val;
        case (fun3)
          3'b000, 3'b001: dec_fun = FUN_XOR;
          3'b100, 3'b101: dec_fun = FUN_SUB;
          3'b110, 3'b111: dec_fun = FUN_SUB_U;
          default:        dec_ill = 1'b1;
        endcase
      end
      OP_LD: begin
        dec_rs1 = 1'b1;
        dec_rd  = 1'b1;
        dec_imm = imm_i;
        dec_op1 = rs1_val;
        dec_op2 = imm_i;
      end
      OP_ST: begin
        dec_rs1 = 1'b1;
        dec_rs2 = 1'b1;
        dec_imm = imm_s;
        dec_op1 = rs1_val;
        dec_op2 = imm_s;
      end
      OP_ALI: begin
        dec_rs1 = 1'b1;
        dec_rd  = 1'b1;
        dec_imm = imm_i;
        dec_op1 = rs1_val;
        dec_op2 = imm_i;
        case (fun3)
          3'b000: dec_fun = FUN_ADD;
          3'b001: begin
            dec_fun = FUN_SLL;
            dec_ill = shl_bad;
          end
          3'b010: dec_fun = FUN_SUB;
          3'b011: dec_fun = FUN_SUB_U;
          3'b100: dec_fun = FUN_XOR;
          3'b101: begin
            dec_fun = if_instr_i[30] ? FUN_SRA : FUN_SRL;
            dec_ill = shr_bad;
          end
          3'b110: dec_fun = FUN_OR;
          default: dec_fun = FUN_AND;
        endcase
      end
      OP_AL: begin
        dec_rs1 = 1'b1;
        dec_rs2 = 1'b1;
        dec_rd  = 1'b1;
        dec_op1 = rs1_val;
        dec_op2 = rs2_val;
        case (fun7)
          7'b0000000: begin
            case (fun3)
              3'b000:  dec_fun = FUN_ADD;
              3'b001:  dec_fun = FUN_SLL;
              3'b010:  dec_fun = FUN_SUB;
              3'b011:  dec_fun = FUN_SUB_U;
              3'b100:  dec_fun = FUN_XOR;
              3'b101:  dec_fun = FUN_SRL;
              3'b110:  dec_fun = FUN_OR;
              default: dec_fun = FUN_AND;
            endcase
          end
          7'b0100000: begin
            if (fun3 == 3'b000)      dec_fun = FUN_SUB;
            else if (fun3 == 3'b101) dec_fun = FUN_SRA;
            else                     dec_ill = 1'b1;
          end
          7'b0000001: begin
            if (MEXT != 0) dec_fun = FUN_MUL + {2'b00, fun3};
            else           dec_ill = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      OP_CSR: begin
        // fun3[2] selects the zero-extended uimm form, which reads no register
        dec_rs1 = !fun3[2];
        dec_rd  = 1'b1;
        dec_imm = imm_i;
        dec_op1 = fun3[2] ? zimm_ext : rs1_val;
      end
      default: dec_ill = 1'b1;
    endcase

    // An illegal instruction flows as an inert ADD of zeros and reads no
    // registers, so it can never take part in a load-use stall.
    if (dec_ill) begin
      dec_rs1 = 1'b0;
      dec_rs2 = 1'b0;
      dec_rd  = 1'b0;
      dec_fun = FUN_ADD;
      dec_imm = '0;
      dec_op1 = '0;
      dec_op2 = '0;
    end
  end

  assign rs1_idx_o = if_instr_i[19:15];
  assign rs2_idx_o = if_instr_i[24:20];
  assign rs1_en_o  = if_valid_i & dec_rs1;
  assign rs2_en_o  = if_valid_i & dec_rs2;

  logic load_use, drain, accept;
  assign load_use = if_valid_i & ex_ld_valid_i & (ex_ld_rd_i != '0) &
                    ((rs1_en_o & (rs1_idx_o == ex_ld_rd_i)) |
                     (rs2_en_o & (rs2_idx_o == ex_ld_rd_i)));

  // ID/EX register
  logic                      ex_valid_q,  ex_valid_d;
  logic [`PC_WIDTH-1:0]      ex_pc_q,     ex_pc_d;
  logic [`INSTR_WIDTH-1:0]   ex_instr_q,  ex_instr_d;
  logic [`REG_IDX_WIDTH-1:0] ex_rd_idx_q, ex_rd_idx_d;
  logic                      ex_rd_en_q,  ex_rd_en_d;
  logic [XLEN-1:0]           ex_imm_q,    ex_imm_d;
  logic [XLEN-1:0]           ex_op1_q,    ex_op1_d;
  logic [XLEN-1:0]           ex_op2_q,    ex_op2_d;
  logic [4:0]                ex_fun_q,    ex_fun_d;
  logic                      ex_ill_q,    ex_ill_d;
  logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;

  assign drain      = !ex_valid_q | ex_ready_i;
  assign if_ready_o = drain & !load_use & !flush_i;
  assign accept     = if_valid_i & if_ready_o;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_pc_d     = ex_pc_q;
    ex_instr_d  = ex_instr_q;
    ex_rd_idx_d = ex_rd_idx_q;
    ex_rd_en_d  = ex_rd_en_q;
    ex_imm_d    = ex_imm_q;
    ex_op1_d    = ex_op1_q;
    ex_op2_d    = ex_op2_q;
    ex_fun_d    = ex_fun_q;
    ex_ill_d    = ex_ill_q;
    stall_cnt_d = stall_cnt_q;

    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (drain) begin
      // A load-use hazard leaves accept low here, which inserts the bubble
      ex_valid_d = accept;
      if (accept) begin
        ex_pc_d     = if_pc_i;
        ex_instr_d  = if_instr_i;
        ex_rd_idx_d = rd_idx;
        ex_rd_en_d  = dec_rd & (rd_idx != 5'd0);
        ex_imm_d    = dec_imm;
        ex_op1_d    = dec_op1;
        ex_op2_d    = dec_op2;
        ex_fun_d    = dec_fun;
        ex_ill_d    = dec_ill;
      end
    end

    // Counts even during a flush; saturates instead of wrapping
    if (load_use && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_pc_q     <= '0;
      ex_instr_q  <= '0;
      ex_rd_idx_q <= '0;
      ex_rd_en_q  <= 1'b0;
      ex_imm_q    <= '0;
      ex_op1_q    <= '0;
      ex_op2_q    <= '0;
      ex_fun_q    <= '0;
      ex_ill_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_pc_q     <= ex_pc_d;
      ex_instr_q  <= ex_instr_d;
      ex_rd_idx_q <= ex_rd_idx_d;
      ex_rd_en_q  <= ex_rd_en_d;
      ex_imm_q    <= ex_imm_d;
      ex_op1_q    <= ex_op1_d;
      ex_op2_q    <= ex_op2_d;
      ex_fun_q    <= ex_fun_d;
      ex_ill_q    <= ex_ill_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign ex_pc_o      = ex_pc_q;
  assign ex_instr_o   = ex_instr_q;
  assign ex_rd_idx_o  = ex_rd_idx_q;
  assign ex_rd_en_o   = ex_rd_en_q;
  assign ex_imm_o     = ex_imm_q;
  assign ex_alu_op1_o = ex_op1_q;
  assign ex_alu_op2_o = ex_op2_q;
  assign ex_alu_fun_o = ex_fun_q;
  assign ex_illegal_o = ex_ill_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif

module tb_decode_stage;

  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for both instances (MEXT=0 and MEXT=1)
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_pc, in_instr, in_r1, in_r2;
  logic        in_ld_v;
  logic [4:0]  in_ld_rd;
  logic        in_flush, in_ex_ready;

  logic          if_ready [2];
  logic [4:0]    rs1_idx [2], rs2_idx [2];
  logic          rs1_en [2], rs2_en [2];
  logic          ex_valid [2];
  logic [31:0]   ex_pc [2], ex_instr [2], ex_imm [2], ex_op1 [2], ex_op2 [2];
  logic [4:0]    ex_rd [2], ex_fun [2];
  logic          ex_rd_en [2], ex_ill [2];
  logic [CW-1:0] stall_cnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    decode_stage #(.XLEN(32), .MEXT(g), .CNT_W(CW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid_i(in_valid), .if_ready_o(if_ready[g]),
      .if_pc_i(in_pc), .if_instr_i(in_instr),
      .rs1_idx_o(rs1_idx[g]), .rs2_idx_o(rs2_idx[g]),
      .rs1_en_o(rs1_en[g]), .rs2_en_o(rs2_en[g]),
      .rs1_rdata_i(in_r1), .rs2_rdata_i(in_r2),
      .ex_ld_valid_i(in_ld_v), .ex_ld_rd_i(in_ld_rd),
      .flush_i(in_flush),
      .ex_valid_o(ex_valid[g]), .ex_ready_i(in_ex_ready),
      .ex_pc_o(ex_pc[g]), .ex_instr_o(ex_instr[g]),
      .ex_rd_idx_o(ex_rd[g]), .ex_rd_en_o(ex_rd_en[g]),
      .ex_imm_o(ex_imm[g]), .ex_alu_op1_o(ex_op1[g]), .ex_alu_op2_o(ex_op2[g]),
      .ex_alu_fun_o(ex_fun[g]), .ex_illegal_o(ex_ill[g]),
      .stall_cnt_o(stall_cnt[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        ill, r1u, r2u, rden;
    logic [4:0]  fun;
    logic [31:0] imm, op1, op2;
  } dec_t;

  typedef struct {
    logic        v;
    logic [31:0] pc, instr, imm, op1, op2;
    logic [4:0]  rd, fun;
    logic        rden, ill;
    int          cnt;
  } st_t;

  st_t st [2];
  st_t nxt [2];

  // Reference decode, written from the instruction-set rules mnemonic by mnemonic
  function automatic dec_t model_decode(input logic [31:0] i, input bit mext,
                                        input logic [31:0] pc, input logic [31:0] r1,
                                        input logic [31:0] r2);
    dec_t d;
    logic [4:0]  tbl [8];
    logic [31:0] a, b, im_i, im_s, im_b, im_j, im_u;
    logic [2:0]  f3;
    logic [6:0]  f7;
    tbl = '{5'd0, 5'd3, 5'd1, 5'd2, 5'd6, 5'd4, 5'd7, 5'd8};
    f3 = i[14:12];
    f7 = i[31:25];
    im_i = 32'($signed(i) >>> 20);
    im_s = (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
    im_b = (32'($signed(i) >>> 31) << 12) | (32'(i[7]) << 11) |
           (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
    im_j = (32'($signed(i) >>> 31) << 20) | (32'(i[19:12]) << 12) |
           (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
    im_u = i & 32'hFFFF_F000;
    a = (i[19:15] == 0) ? 32'd0 : r1;
    b = (i[24:20] == 0) ? 32'd0 : r2;
    d = '{ill: 0, r1u: 0, r2u: 0, rden: 0, fun: 0, imm: 0, op1: 0, op2: 0};
    case (i[6:0])
      7'h37: begin d.rden = 1; d.imm = im_u; d.op2 = im_u; end
      7'h17: begin d.rden = 1; d.imm = im_u; d.op1 = pc; d.op2 = im_u; end
      7'h6F: begin d.rden = 1; d.imm = im_j; d.op1 = pc; d.op2 = im_j; end
      7'h67: begin d.rden = 1; d.r1u = 1; d.imm = im_i; d.op1 = a; d.op2 = im_i; end
      7'h03: begin d.rden = 1; d.r1u = 1; d.imm = im_i; d.op1 = a; d.op2 = im_i; end
      7'h23: begin d.r1u = 1; d.r2u = 1; d.imm = im_s; d.op1 = a; d.op2 = im_s; end
      7'h63: begin
        d.r1u = 1; d.r2u = 1; d.imm = im_b; d.op1 = a; d.op2 = b;
        if (f3 == 2 || f3 == 3) d.ill = 1;
        else d.fun = (f3 < 4) ? 5'd6 : (f3 < 6) ? 5'd1 : 5'd2;
      end
      7'h13: begin
        d.rden = 1; d.r1u = 1; d.imm = im_i; d.op1 = a; d.op2 = im_i;
        d.fun = tbl[f3];
        if (f3 == 5 && i[30]) d.fun = 5'd5;
        if (f3 == 1 && f7 != 0) d.ill = 1;
        if (f3 == 5 && (f7 & 7'b1011111) != 0) d.ill = 1;
      end
      7'h33: begin
        d.rden = 1; d.r1u = 1; d.r2u = 1; d.op1 = a; d.op2 = b;
        if (f7 == 0) d.fun = tbl[f3];
        else if (f7 == 7'h20 && f3 == 0) d.fun = 5'd1;
        else if (f7 == 7'h20 && f3 == 5) d.fun = 5'd5;
        else if (f7 == 7'h01 && mext) d.fun = 5'(10 + f3);
        else d.ill = 1;
      end
      7'h73: begin
        d.rden = 1; d.r1u = !f3[2]; d.imm = im_i;
        d.op1 = f3[2] ? 32'(i[19:15]) : a;
      end
      default: d.ill = 1;
    endcase
    if (d.ill) d = '{ill: 1, r1u: 0, r2u: 0, rden: 0, fun: 0, imm: 0, op1: 0, op2: 0};
    if (i[11:7] == 0) d.rden = 0;
    return d;
  endfunction

  // One clock: check combinational outputs before the edge, advance the
  // model, then check the registered outputs after the edge.
  task automatic step();
    dec_t d;
    logic lu, rdy;
    #3;
    for (int m = 0; m < 2; m++) begin
      d = model_decode(in_instr, m[0], in_pc, in_r1, in_r2);
      lu = in_valid & in_ld_v & (in_ld_rd != 0) &
           ((d.r1u & (in_instr[19:15] == in_ld_rd)) | (d.r2u & (in_instr[24:20] == in_ld_rd)));
      rdy = (!st[m].v | in_ex_ready) & !lu & !in_flush;
      check($sformatf("rs1_idx[%0d]", m), 64'(rs1_idx[m]), 64'(in_instr[19:15]));
      check($sformatf("rs2_idx[%0d]", m), 64'(rs2_idx[m]), 64'(in_instr[24:20]));
      check($sformatf("rs1_en[%0d]", m), 64'(rs1_en[m]), 64'(in_valid & d.r1u));
      check($sformatf("rs2_en[%0d]", m), 64'(rs2_en[m]), 64'(in_valid & d.r2u));
      check($sformatf("if_ready[%0d]", m), 64'(if_ready[m]), 64'(rdy));
      nxt[m] = st[m];
      if (!rst_n) begin
        nxt[m] = '{v: 0, pc: 0, instr: 0, imm: 0, op1: 0, op2: 0, rd: 0, fun: 0,
                   rden: 0, ill: 0, cnt: 0};
      end else begin
        if (lu) nxt[m].cnt = (st[m].cnt + 1 > 15) ? 15 : st[m].cnt + 1;
        if (in_flush) nxt[m].v = 0;
        else if (!st[m].v || in_ex_ready) begin
          nxt[m].v = in_valid & rdy;
          if (in_valid & rdy) begin
            nxt[m].pc = in_pc; nxt[m].instr = in_instr; nxt[m].rd = in_instr[11:7];
            nxt[m].rden = d.rden; nxt[m].imm = d.imm; nxt[m].op1 = d.op1;
            nxt[m].op2 = d.op2; nxt[m].fun = d.fun; nxt[m].ill = d.ill;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    st = nxt;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("ex_valid[%0d]", m), 64'(ex_valid[m]), 64'(st[m].v));
      check($sformatf("ex_pc[%0d]", m), 64'(ex_pc[m]), 64'(st[m].pc));
      check($sformatf("ex_instr[%0d]", m), 64'(ex_instr[m]), 64'(st[m].instr));
      check($sformatf("ex_rd[%0d]", m), 64'(ex_rd[m]), 64'(st[m].rd));
      check($sformatf("ex_rd_en[%0d]", m), 64'(ex_rd_en[m]), 64'(st[m].rden));
      check($sformatf("ex_imm[%0d]", m), 64'(ex_imm[m]), 64'(st[m].imm));
      check($sformatf("ex_op1[%0d]", m), 64'(ex_op1[m]), 64'(st[m].op1));
      check($sformatf("ex_op2[%0d]", m), 64'(ex_op2[m]), 64'(st[m].op2));
      check($sformatf("ex_fun[%0d]", m), 64'(ex_fun[m]), 64'(st[m].fun));
      check($sformatf("ex_ill[%0d]", m), 64'(ex_ill[m]), 64'(st[m].ill));
      check($sformatf("stall_cnt[%0d]", m), 64'(stall_cnt[m]), 64'(st[m].cnt));
    end
  endtask

  task automatic idle();
    in_valid = 0; in_ld_v = 0; in_ld_rd = 0; in_flush = 0; in_ex_ready = 1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [6:0]  f7s [3];
    logic [31:0] i;
    int k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    f7s = '{7'h00, 7'h20, 7'h01};
    i = $urandom;
    k = $urandom_range(0, 11);
    if (k < 10) i[6:0] = ops[k];
    if ($urandom_range(0, 2) != 0) i[31:25] = f7s[$urandom_range(0, 2)];
    if ($urandom_range(0, 1) != 0) begin
      i[19:15] = 5'($urandom_range(0, 3));
      i[24:20] = 5'($urandom_range(0, 3));
    end
    if ($urandom_range(0, 7) == 0) i[11:7] = 0;
    return i;
  endfunction

  initial begin
    rst_n = 0; idle();
    in_pc = 32'h1000; in_instr = 32'h0000_0013; in_r1 = 0; in_r2 = 0;
    for (int m = 0; m < 2; m++)
      st[m] = '{v: 0, pc: 0, instr: 0, imm: 0, op1: 0, op2: 0, rd: 0, fun: 0,
                rden: 0, ill: 0, cnt: 0};
    @(posedge clk);
    #1;
    step();
    check("reset_valid", 64'(ex_valid[0]), 64'd0);
    rst_n = 1;

    // addi x1,x2,-1
    in_valid = 1; in_instr = 32'hFFF1_0093; in_r1 = 5; in_r2 = 32'hDEAD;
    step();
    check("addi_valid", 64'(ex_valid[0]), 64'd1);
    check("addi_op1", 64'(ex_op1[0]), 64'd5);
    check("addi_op2", 64'(ex_op2[0]), 64'hFFFF_FFFF);
    check("addi_fun", 64'(ex_fun[0]), 64'd0);
    check("addi_rd", 64'(ex_rd[0]), 64'd1);
    check("addi_rd_en", 64'(ex_rd_en[0]), 64'd1);

    // load-use on x2: bubble, then accepted once the load leaves
    in_ld_v = 1; in_ld_rd = 2; in_instr = 32'h0041_01B3;
    #3;
    check("lu_if_ready", 64'(if_ready[0]), 64'd0);
    #2;
    step();
    check("lu_bubble", 64'(ex_valid[0]), 64'd0);
    check("lu_cnt", 64'(stall_cnt[0]), 64'd1);
    in_ld_v = 0;
    step();
    check("lu_accept", 64'(ex_valid[0]), 64'd1);
    check("lu_rd", 64'(ex_rd[0]), 64'd3);
    check("lu_fun", 64'(ex_fun[0]), 64'd0);

    // backpressure: EX holds for 3 cycles
    in_ex_ready = 0; in_instr = 32'h0020_8133; in_pc = 32'h2000;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_hold_instr", 64'(ex_instr[0]), 64'h0041_01B3);
    end
    in_ex_ready = 1;
    step();
    check("bp_release", 64'(ex_instr[0]), 64'h0020_8133);

    // flush kills the slot
    in_flush = 1; in_instr = 32'h0030_0093;
    step();
    check("flush_valid", 64'(ex_valid[0]), 64'd0);
    in_flush = 0;

    // mul x1,x2,x3 on both instances
    in_instr = 32'h0231_00B3;
    step();
    check("mul_ill_m0", 64'(ex_ill[0]), 64'd1);
    check("mul_rden_m0", 64'(ex_rd_en[0]), 64'd0);
    check("mul_fun_m1", 64'(ex_fun[1]), 64'd10);
    check("mul_rden_m1", 64'(ex_rd_en[1]), 64'd1);

    // counter saturation, one stalled cycle also flushed
    in_ld_v = 1; in_ld_rd = 2; in_instr = 32'h0001_0093;
    for (int c = 0; c < 20; c++) begin
      in_flush = (c == 7);
      step();
    end
    in_flush = 0;
    check("cnt_sat", 64'(stall_cnt[0]), 64'd15);

    // reset mid-transfer with stall_cnt=5
    rst_n = 0; step(); rst_n = 1;
    in_instr = 32'h0041_01B3;
    for (int c = 0; c < 5; c++) step();
    check("cnt_five", 64'(stall_cnt[0]), 64'd5);
    in_ld_v = 0; in_ex_ready = 0; in_pc = 32'h3000;
    step();
    check("pre_rst_valid", 64'(ex_valid[0]), 64'd1);
    rst_n = 0;
    step();
    check("rst_valid", 64'(ex_valid[0]), 64'd0);
    check("rst_cnt", 64'(stall_cnt[0]), 64'd0);
    check("rst_pc", 64'(ex_pc[0]), 64'd0);
    check("rst_op1", 64'(ex_op1[0]), 64'd0);
    rst_n = 1; idle();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_instr    = rand_instr();
      in_pc       = $urandom;
      in_r1       = $urandom;
      in_r2       = $urandom;
      in_ld_v     = 1'($urandom_range(0, 1));
      in_ld_rd    = 5'($urandom_range(0, 3));
      in_flush    = ($urandom_range(0, 15) == 0);
      in_ex_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
